prom_patch_writer: RTL and testbench



---
 rtl/prom_patch_pkg.sv | 28 ++
 rtl/prom_patch_ram.sv | 28 ++
 rtl/prom_patch_writer.sv | 106 ++++++++++
 tb/tb_prom_patch_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prom_patch_pkg.sv
// Shared constants and types for the PROM patch writer and its shadow RAM.
package prom_patch_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 49;
  localparam int CNT_W  = 10;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_BYTE  = 8'h5A;

  // SYNC + A0 + A1 + D0..D6 + CK
  localparam int REC_LEN    = 11;
  localparam int ADDR_BYTES = 2;
  localparam int DATA_BYTES = REC_LEN - ADDR_BYTES - 2;

  // Last byte index within the ADDR and DATA phases
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

endpackage

// File: rtl/prom_patch_ram.sv
// 512 x DATA_W shadow PROM: one write port, one registered read port.
// A read and a write to the same word in one cycle returns the old word.
module prom_patch_ram
  import prom_patch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write port; contents are never reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port with a resettable output register
  always_ff @(posedge clk) begin
    if (reset) o_rdata <= '0;
    else       o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/prom_patch_writer.sv
// Parses framed patch records from a byte stream, checks checksum and pad
// bits, and writes good words into the PROM shadow at the inverted address.
// Handshake: a byte moves on every rising edge where in_valid and in_ready are
// both high; in_valid may drop at any time, in_ready is low only during reset
// and for the single WRITE cycle.
module prom_patch_writer
  import prom_patch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  patch_count,
  output state_t            dbg_state
);

  state_t            r_state, w_next;
  logic [2:0]        r_idx;
  logic [7:0]        r_xor;
  logic [15:0]       r_addr_asm;
  logic [55:0]       r_data_asm;
  logic              r_done, r_err;
  logic [CNT_W-1:0]  r_count;

  logic w_accept, w_pads_ok, w_good, w_we;

  assign in_ready    = !reset && (r_state != ST_WRITE);
  assign w_accept    = in_valid && in_ready;
  assign w_pads_ok   = (r_addr_asm[15:ADDR_W] == '0) && (r_data_asm[55:DATA_W] == '0);
  assign w_good      = (in_data == r_xor) && w_pads_ok;
  assign w_we        = (r_state == ST_WRITE) && !reset;
  assign done        = r_done;
  assign err         = r_err;
  assign patch_count = r_count;
  assign dbg_state   = r_state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && in_data == SYNC_BYTE) w_next = ST_ADDR;
      ST_ADDR:  if (w_accept && r_idx == ADDR_LAST)   w_next = ST_DATA;
      ST_DATA:  if (w_accept && r_idx == DATA_LAST)   w_next = ST_CSUM;
      ST_CSUM:  if (w_accept) w_next = w_good ? ST_WRITE : ST_IDLE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Assembly, running checksum, status flags and good-record counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_xor      <= '0;
      r_addr_asm <= '0;
      r_data_asm <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_done <= w_accept && (r_state == ST_IDLE) && (in_data == END_BYTE);
      case (r_state)
        ST_IDLE: if (w_accept && in_data == SYNC_BYTE) begin
          r_xor <= '0;
          r_idx <= '0;
        end
        // Bytes shift in from the top so the last byte ends up most significant
        ST_ADDR: if (w_accept) begin
          r_addr_asm <= {in_data, r_addr_asm[15:8]};
          r_xor      <= r_xor ^ in_data;
          r_idx      <= (r_idx == ADDR_LAST) ? 3'd0 : r_idx + 3'd1;
        end
        ST_DATA: if (w_accept) begin
          r_data_asm <= {in_data, r_data_asm[55:8]};
          r_xor      <= r_xor ^ in_data;
          r_idx      <= (r_idx == DATA_LAST) ? 3'd0 : r_idx + 3'd1;
        end
        ST_CSUM: if (w_accept && !w_good) r_err <= 1'b1;
        ST_WRITE: if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
        default: ;
      endcase
    end
  end

  prom_patch_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (~r_addr_asm[ADDR_W-1:0]),
    .i_wdata (r_data_asm[DATA_W-1:0]),
    .i_raddr (addr),
    .o_rdata (q)
  );

endmodule

// File: tb/tb_prom_patch_writer.sv
// Self-checking bench for prom_patch_writer: directed record scenarios plus
// randomized traffic, compared against a record-level reference model.
module tb_prom_patch_writer;
  import prom_patch_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] q;
  logic              done, err;
  logic [CNT_W-1:0]  patch_count;
  state_t            dbg_state;

  prom_patch_writer dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .addr        (addr),
    .q           (q),
    .done        (done),
    .err         (err),
    .patch_count (patch_count),
    .dbg_state   (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] mem_m [512];
  bit                known [512];
  int                count_m  = 0;
  bit                err_m    = 0;
  int                done_exp = 0;
  int                done_cnt = 0;
  bit                gap_en   = 1;
  logic [ADDR_W-1:0] exp_q [$];   // words written by good records

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count every cycle on which done is high
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Record-level model: a good record lands at word 511 - address
  task automatic model_record(input logic [8:0] a, input logic [48:0] d, input bit good);
    int w;
    if (good) begin
      w = 511 - int'(a);
      mem_m[w] = d;
      known[w] = 1'b1;
      exp_q.push_back(ADDR_W'(w));
      if (count_m < 1023) count_m++;
    end else begin
      err_m = 1'b1;
    end
  endtask

  // Driver tasks: all start and end 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap, w;
    gap = 0;
    if (gap_en && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_record(input logic [8:0] a, input logic [48:0] d, input bit bad_ck,
                             input bit pad_a1, input bit pad_d6, input int nbytes);
    logic [7:0]  b [11];
    logic [55:0] dd;
    logic [7:0]  x;
    dd   = {7'b0, d};
    b[0] = SYNC_BYTE;
    b[1] = a[7:0];
    b[2] = {7'b0, a[8]} | (pad_a1 ? 8'h02 : 8'h00);
    for (int k = 0; k < 7; k++) b[3+k] = dd[8*k +: 8];
    b[9] = b[9] | (pad_d6 ? 8'h80 : 8'h00);
    x = 8'h00;
    for (int k = 1; k <= 9; k++) x = x ^ b[k];
    b[10] = x ^ (bad_ck ? 8'h01 : 8'h00);
    for (int k = 0; k < nbytes; k++) send_byte(b[k]);
    if (nbytes == 11) model_record(a, d, !(bad_ck || pad_a1 || pad_d6));
  endtask

  task automatic send_end();
    send_byte(END_BYTE);
    done_exp++;
  endtask

  task automatic read_chk(input logic [8:0] w, input string tag);
    addr = w;
    @(posedge clk);
    @(negedge clk);
    if (known[w]) chk(tag, 64'(q), 64'(mem_m[w]));
    @(posedge clk); #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 64'(patch_count), 64'(count_m));
    chk({tag, "_err"},   64'(err),         64'(err_m));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_q",      64'(q),           64'd0);
    chk("rst_done",   64'(done),        64'd0);
    chk("rst_err",    64'(err),         64'd0);
    chk("rst_count",  64'(patch_count), 64'd0);
    chk("rst_ready",  64'(in_ready),    64'd0);
    chk("rst_state",  64'(dbg_state),   64'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    count_m = 0;
    err_m   = 1'b0;
  endtask

  initial begin
    logic [8:0]  ra;
    logic [48:0] rd;
    logic [7:0]  jb;
    int          r;

    for (int i = 0; i < 512; i++) known[i] = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Good record at address 0 lands at word 511
    send_record(9'h000, 49'h1_2345_6789_ABCD, 0, 0, 0, 11);
    idle(2);
    read_chk(9'h1FF, "t1_read_model");
    addr = 9'h1FF; @(posedge clk); @(negedge clk);
    chk("t1_read_const", 64'(q), 64'h1_2345_6789_ABCD);
    @(posedge clk); #1;
    check_status("t1");

    // Flipped checksum: no write, err set, next good record still accepted
    send_record(9'h000, 49'h0_0000_0000_0F0F, 1, 0, 0, 11);
    idle(2);
    addr = 9'h1FF; @(posedge clk); @(negedge clk);
    chk("t2_word_kept", 64'(q), 64'h1_2345_6789_ABCD);
    @(posedge clk); #1;
    check_status("t2");
    send_record(9'h010, 49'(64'({$urandom(), $urandom()})), 0, 0, 0, 11);
    idle(2);
    check_status("t2_next_good");
    read_chk(9'h1EF, "t2_next_read");

    // Pad bits set with a consistent checksum
    do_reset();
    send_record(9'h033, 49'h0_1111_2222_3333, 0, 1, 0, 11);
    idle(2);
    check_status("t3_pad_a1");
    do_reset();
    send_record(9'h034, 49'h0_4444_5555_6666, 0, 0, 1, 11);
    idle(2);
    check_status("t3_pad_d6");

    // Duplicate address: last write wins, then END pulses done once
    do_reset();
    send_record(9'h005, 49'd1, 0, 0, 0, 11);
    send_record(9'h005, 49'd2, 0, 0, 0, 11);
    send_end();
    @(negedge clk);
    chk("t4_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    chk("t4_done_low", 64'(done), 64'd0);
    @(posedge clk); #1;
    read_chk(9'h1FA, "t4_dup_read");
    check_status("t4");

    // Read of the word in the same cycle it is written returns the old value
    send_record(9'h005, 49'd3, 0, 0, 0, 11);
    addr = 9'h1FA;
    @(negedge clk);
    chk("t5_ready_in_write", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_old_value", 64'(q), 64'd2);
    chk("t5_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("t5_new_value", 64'(q), 64'd3);
    @(posedge clk); #1;

    // Reset after D3 drops the partial record
    do_reset();
    send_record(9'h0AA, 49'h0_DEAD_BEEF_0001, 0, 0, 0, 7);
    do_reset();
    check_status("t6_after_rst");
    send_record(9'h0AB, 49'(64'({$urandom(), $urandom()})), 0, 0, 0, 11);
    idle(2);
    check_status("t6");
    read_chk(9'h154, "t6_read");

    // Randomized traffic: records (some corrupted), junk bytes, END markers
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_end();
      end else if (r == 1) begin
        do jb = 8'($urandom_range(0, 255)); while (jb == SYNC_BYTE || jb == END_BYTE);
        send_byte(jb);
      end else begin
        ra = 9'($urandom_range(0, 511));
        rd = 49'(64'({$urandom(), $urandom()}));
        send_record(ra, rd, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0, 11);
      end
    end
    idle(2);
    check_status("rand");
    while (exp_q.size() > 0) read_chk(exp_q.pop_front(), "rand_read");

    // Counter saturation
    do_reset();
    gap_en = 0;
    for (int i = 0; i < 1030; i++)
      send_record(9'($urandom_range(0, 511)), 49'(64'({$urandom(), $urandom()})), 0, 0, 0, 11);
    idle(2);
    check_status("sat");
    chk("sat_value", 64'(patch_count), 64'd1023);
    exp_q.delete();

    idle(2);
    chk("done_pulses", 64'(done_cnt), 64'(done_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
